// File: rtl/fft_unload_if.sv
// Handshake and bank-read bundle between the FFT result unloader and its environment.
// Purpose: groups the start/ready controls, the four bank read ports and the output stream.
// Ports: master = unloader side (drives addresses and the stream); slave = core RAMs plus sink.
interface fft_unload_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 17
);
  logic              iSTART;
  logic              iFFT_RDY;
  logic [ADDR_W-1:0] oADDR_RD_0;
  logic [ADDR_W-1:0] oADDR_RD_1;
  logic [ADDR_W-1:0] oADDR_RD_2;
  logic [ADDR_W-1:0] oADDR_RD_3;
  logic [DATA_W-1:0] iDATA_RE_0;
  logic [DATA_W-1:0] iDATA_RE_1;
  logic [DATA_W-1:0] iDATA_RE_2;
  logic [DATA_W-1:0] iDATA_RE_3;
  logic [DATA_W-1:0] oDATA;
  logic              oVALID;
  logic              iREADY;
  logic              oLAST;
  logic              oBUSY;
  logic              oDONE;

  modport master (
    input  iSTART, iFFT_RDY, iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3, iREADY,
    output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3, oDATA, oVALID, oLAST, oBUSY, oDONE
  );

  modport slave (
    output iSTART, iFFT_RDY, iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3, iREADY,
    input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3, oDATA, oVALID, oLAST, oBUSY, oDONE
  );
endinterface

// File: rtl/fft_unload.sv
// Purpose: streams the 2048 real FFT results out of four interleaved RAM banks in natural order.
// Latency: start sampled in cycle 0, address 0 in cycle 1, sample 0 valid in cycle 3; 1 word/cycle.
// Backpressure: credit-limited reads into a FIFO_D-deep buffer; head held stable while iREADY is low.
// Ports: iCLK, iRESET (async, active-low), bus (fft_unload_if.master: start/ready controls,
//        four registered bank read addresses, bank read data, oDATA/oVALID/iREADY/oLAST stream,
//        oBUSY level and oDONE pulse).
module fft_unload #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 17,
  parameter int FIFO_D = 4
) (
  input logic          iCLK,
  input logic          iRESET,
  fft_unload_if.master bus
);

  localparam int IDX_W = ADDR_W + 2;
  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W = $clog2(FIFO_D + 1);
  localparam int CRD_W = CNT_W + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Issue stage: address is on the ports this cycle, data returns next cycle.
  logic              s1_vld_q, s1_vld_d;
  logic [1:0]        s1_sel_q, s1_sel_d;
  logic              s1_last_q, s1_last_d;

  // RAM stage: bank data is present this cycle and is pushed at the next edge.
  logic              s2_vld_q;
  logic [1:0]        s2_sel_q;
  logic              s2_last_q;

  // Output FIFO, entry = {last, data}.
  logic [DATA_W:0]   mem_q [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              start_ok;
  logic              credit_ok;
  logic              issue;
  logic [IDX_W-1:0]  issue_idx;
  logic [CRD_W-1:0]  crd_used;
  logic              push;
  logic              pop;
  logic              head_vld;
  logic              head_last;
  logic [DATA_W:0]   push_dat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign start_ok  = (state_q == ST_IDLE) && bus.iSTART && bus.iFFT_RDY;
  // Occupancy plus every read still in the pipe must leave room, so the FIFO can never overflow.
  assign crd_used  = CRD_W'(cnt_q) + CRD_W'(s1_vld_q) + CRD_W'(s2_vld_q);
  assign credit_ok = crd_used < CRD_W'(FIFO_D);
  // The accepting edge itself issues index 0 so address 0 is on the ports one cycle after start.
  assign issue     = start_ok || ((state_q == ST_READ) && credit_ok);
  assign issue_idx = start_ok ? '0 : issue_cnt_q;

  assign head_vld  = (cnt_q != '0);
  assign head_last = head_vld && mem_q[rd_ptr_q][DATA_W];
  assign push      = s2_vld_q;
  assign pop       = head_vld && bus.iREADY;

  always_comb begin
    push_dat = {s2_last_q, bus.iDATA_RE_0};
    case (s2_sel_q)
      2'd1:    push_dat = {s2_last_q, bus.iDATA_RE_1};
      2'd2:    push_dat = {s2_last_q, bus.iDATA_RE_2};
      2'd3:    push_dat = {s2_last_q, bus.iDATA_RE_3};
      default: push_dat = {s2_last_q, bus.iDATA_RE_0};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    addr_d      = addr_q;
    s1_vld_d    = issue;
    s1_sel_d    = s1_sel_q;
    s1_last_d   = s1_last_q;
    if (issue) begin
      addr_d      = issue_idx[IDX_W-1:2];
      s1_sel_d    = issue_idx[1:0];
      s1_last_d   = &issue_idx;
      issue_cnt_d = issue_idx + IDX_W'(1);
    end
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_READ;
      ST_READ:  if (issue && (&issue_cnt_q)) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && head_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (start_ok) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  assign done_d = (state_q == ST_DRAIN) && pop && head_last;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      addr_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_sel_q    <= '0;
      s1_last_q   <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_sel_q    <= '0;
      s2_last_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < FIFO_D; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      addr_q      <= addr_d;
      s1_vld_q    <= s1_vld_d;
      s1_sel_q    <= s1_sel_d;
      s1_last_q   <= s1_last_d;
      s2_vld_q    <= s1_vld_q;
      s2_sel_q    <= s1_sel_q;
      s2_last_q   <= s1_last_q;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      if (push) mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign bus.oADDR_RD_0 = addr_q;
  assign bus.oADDR_RD_1 = addr_q;
  assign bus.oADDR_RD_2 = addr_q;
  assign bus.oADDR_RD_3 = addr_q;
  assign bus.oDATA      = mem_q[rd_ptr_q][DATA_W-1:0];
  assign bus.oVALID     = head_vld;
  assign bus.oLAST      = head_last;
  assign bus.oBUSY      = (state_q != ST_IDLE);
  assign bus.oDONE      = done_q;

endmodule

// File: tb/tb_fft_unload.sv
// Bench for fft_unload: banked RAM model, reference stream from the bank/address mapping,
// random and patterned backpressure, rejected starts, mid-stream reset and back-to-back unloads.
module tb_fft_unload;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 17;
  localparam int FIFO_D = 4;
  localparam int NSAMP  = 2048;

  logic clk;
  logic rst_n;

  fft_unload_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fft_unload #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_D(FIFO_D)) dut (
    .iCLK  (clk),
    .iRESET(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram     [4][512];
  logic [DATA_W-1:0] exp_dat [NSAMP];

  // Synchronous-read RAM banks, one cycle of latency.
  always @(posedge clk) begin
    bus.iDATA_RE_0 <= ram[0][bus.oADDR_RD_0];
    bus.iDATA_RE_1 <= ram[1][bus.oADDR_RD_1];
    bus.iDATA_RE_2 <= ram[2][bus.oADDR_RD_2];
    bus.iDATA_RE_3 <= ram[3][bus.oADDR_RD_3];
  end

  int vec_cnt = 0;
  int err_cnt = 0;
  int max_occ = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Fill banks (pattern 4a+b or random) and derive the natural-order reference stream.
  task automatic fill(input bit rnd);
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 512; a++)
        ram[b][a] = rnd ? DATA_W'($urandom) : DATA_W'(4 * a + b);
    for (int n = 0; n < NSAMP; n++) exp_dat[n] = ram[n % 4][n / 4];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vld"},  32'(bus.oVALID), 0);
    check({tag, "_dat"},  32'(bus.oDATA), 0);
    check({tag, "_last"}, 32'(bus.oLAST), 0);
    check({tag, "_busy"}, 32'(bus.oBUSY), 0);
    check({tag, "_done"}, 32'(bus.oDONE), 0);
    check({tag, "_a0"},   32'(bus.oADDR_RD_0), 0);
    check({tag, "_a3"},   32'(bus.oADDR_RD_3), 0);
  endtask

  // Entered at posedge+1 of cycle 0 with iSTART already driven high by the caller.
  // mode: 0 = always ready, 1 = ~30% random ready, 2 = ready on odd cycles.
  task automatic stream(input int mode, input int reset_at, input int restart_at,
                        input bit chained_in, input bit chain_out, output bit aborted);
    int k, cyc, first;
    bit pv, pr, pl, hs, restart_pend;
    logic [DATA_W-1:0] pd;
    k = 0; cyc = 0; first = -1;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; restart_pend = 1'b0; aborted = 1'b0;
    while (k < NSAMP) begin
      case (mode)
        0:       bus.iREADY = 1'b1;
        1:       bus.iREADY = ($urandom_range(0, 99) < 30);
        default: bus.iREADY = (cyc % 2 == 1);
      endcase
      @(negedge clk);
      if (int'(dut.cnt_q) > max_occ) max_occ = int'(dut.cnt_q);
      if (cyc == 0 && chained_in) begin
        check("b2b_done_pulse", 32'(bus.oDONE), 1);
        check("b2b_busy_low", 32'(bus.oBUSY), 0);
      end
      if (cyc == 1) begin
        check("busy_rise", 32'(bus.oBUSY), 1);
        check("addr_first", 32'(bus.oADDR_RD_0), 0);
      end
      if (bus.oVALID && first < 0) begin
        first = cyc;
        check("first_valid_cycle", 32'(first), 3);
      end
      if (pv && !pr) begin
        check("stall_valid_held", 32'(bus.oVALID), 1);
        check("stall_data_held", 32'(bus.oDATA), 32'(pd));
        check("stall_last_held", 32'(bus.oLAST), 32'(pl));
      end
      hs = bus.oVALID && bus.iREADY;
      pv = bus.oVALID; pr = bus.iREADY; pd = bus.oDATA; pl = bus.oLAST;
      if (hs) begin
        check("sample_data", 32'(bus.oDATA), 32'(exp_dat[k]));
        check("sample_last", 32'(bus.oLAST), 32'(k == NSAMP - 1));
        if (mode == 0 && k == NSAMP - 1) check("last_cycle", 32'(cyc), 2050);
        k++;
        if (k == restart_at) restart_pend = 1'b1;
      end
      if (hs && k == reset_at) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid");
        aborted = 1'b1;
        return;
      end
      @(posedge clk); #1;
      cyc++;
      bus.iSTART = restart_pend;
      restart_pend = 1'b0;
      if (cyc > 12000) begin
        check("stream_timeout", 32'(k), NSAMP);
        aborted = 1'b1;
        return;
      end
    end
    if (mode == 2) check("alt_span_cycles", 32'(cyc >= 4090 && cyc <= 4110), 1);
    bus.iSTART = chain_out;
    if (!chain_out) begin
      @(negedge clk);
      check("done_pulse", 32'(bus.oDONE), 1);
      check("busy_fall", 32'(bus.oBUSY), 0);
      check("valid_after_end", 32'(bus.oVALID), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_one_cycle", 32'(bus.oDONE), 0);
      @(posedge clk); #1;
    end
  endtask

  bit ab;

  initial begin
    rst_n        = 1'b0;
    bus.iSTART   = 1'b0;
    bus.iFFT_RDY = 1'b0;
    bus.iREADY   = 1'b0;
    fill(1'b0);
    #12 check_all_zero("reset_val");
    @(posedge clk); #1 rst_n = 1'b1;

    // Start while the core is not ready must be ignored.
    bus.iSTART = 1'b1;
    @(posedge clk); #1 bus.iSTART = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rej_busy", 32'(bus.oBUSY), 0);
      check("rej_addr", 32'(bus.oADDR_RD_2), 0);
      check("rej_valid", 32'(bus.oVALID), 0);
    end
    @(posedge clk); #1;
    bus.iFFT_RDY = 1'b1;

    // Full-rate unload, pattern 4a+b.
    bus.iSTART = 1'b1;
    stream(0, -1, -1, 1'b0, 1'b0, ab);

    // Random data, random backpressure.
    fill(1'b1);
    bus.iSTART = 1'b1;
    stream(1, -1, -1, 1'b0, 1'b0, ab);

    // Alternating ready.
    max_occ = 0;
    bus.iSTART = 1'b1;
    stream(2, -1, -1, 1'b0, 1'b0, ab);
    check("occ_within_depth", 32'(max_occ <= FIFO_D), 1);

    // Second start mid-stream is ignored.
    fill(1'b1);
    bus.iSTART = 1'b1;
    stream(1, -1, 100, 1'b0, 1'b0, ab);

    // Reset mid-stream, then a fresh unload from sample 0.
    bus.iSTART = 1'b1;
    stream(0, 700, -1, 1'b0, 1'b0, ab);
    check("reset_abort_seen", 32'(ab), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.iSTART = 1'b1;
    stream(0, -1, -1, 1'b0, 1'b0, ab);

    // Back-to-back: second start in the oDONE cycle.
    bus.iSTART = 1'b1;
    stream(0, -1, -1, 1'b0, 1'b1, ab);
    stream(0, -1, -1, 1'b1, 1'b0, ab);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
